zx_kbd_spi_rx: RTL

- SPI slave receiving keyboard matrix and Kempston joystick state from the USB/PS2/SEGA gamepad controller over KBD_CLK, KBD_CS and KBD_DI.
- Holds a committed 8x5 Spectrum matrix and resolves the port #FE key column bits kd[4:0] from CPU address A[15:8].
- Sits directly upstream of the port #FE read path in the top-level CPLD and replaces the current constant 5'b11111.

---
 rtl/zx_kbd_pkg.sv | 16 +
 rtl/zx_sync_edge.sv | 32 +++
 rtl/zx_kbd_spi_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/zx_kbd_pkg.sv
// Shared constants and FSM state type for the ZX Spectrum keyboard SPI receiver.
package zx_kbd_pkg;

   localparam int KBD_ROWS       = 8;
   localparam int KBD_COLS       = 5;
   localparam int KBD_FRAME_BITS = 72;

   localparam logic [KBD_COLS-1:0] KBD_ROW_RELEASED = 5'b11111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } kbd_state_e;

endpackage

// File: rtl/zx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with an edge-history
// flop providing single-cycle rise and fall pulses.
module zx_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic CLK_14MHZ,
   input  logic CPU_RESET,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
      if (!CPU_RESET) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/zx_kbd_spi_rx.sv
// SPI slave receiving the 8x5 Spectrum key matrix plus Kempston byte and
// resolving port #FE kd[4:0]. Optional watchdog: define KBD_WATCHDOG_EN.
module zx_kbd_spi_rx
   import zx_kbd_pkg::*;
#(
   parameter int FRAME_BITS     = KBD_FRAME_BITS,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1400000
) (
   input  logic                CLK_14MHZ,
   input  logic                CPU_RESET,
   input  logic                KBD_CLK,
   input  logic                KBD_CS,
   input  logic                KBD_DI,
   input  logic [7:0]          A_HI,
   output logic [KBD_COLS-1:0] kd,
   output logic [7:0]          kempston,
   output logic                frame_ok,
   output logic                frame_err
);

   localparam int               CNT_W     = 7;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

   // The frame layout is fixed at eight row bytes plus one joystick byte.
   if (FRAME_BITS != KBD_ROWS*8 + 8 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("zx_kbd_spi_rx: unsupported parameter set");
   end

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic di_lvl, di_rise, di_fall;

   zx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
      .CLK_14MHZ (CLK_14MHZ),
      .CPU_RESET (CPU_RESET),
      .async_i   (KBD_CLK),
      .level_o   (sck_lvl),
      .rise_o    (sck_rise),
      .fall_o    (sck_fall)
   );

   zx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .CLK_14MHZ (CLK_14MHZ),
      .CPU_RESET (CPU_RESET),
      .async_i   (KBD_CS),
      .level_o   (cs_lvl),
      .rise_o    (cs_rise),
      .fall_o    (cs_fall)
   );

   zx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_di (
      .CLK_14MHZ (CLK_14MHZ),
      .CPU_RESET (CPU_RESET),
      .async_i   (KBD_DI),
      .level_o   (di_lvl),
      .rise_o    (di_rise),
      .fall_o    (di_fall)
   );

   kbd_state_e                        state_q, state_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [FRAME_BITS-1:0]             shift_q, shift_d;
   logic [KBD_ROWS-1:0][KBD_COLS-1:0] row_q, row_d;
   logic [7:0]                        joy_q, joy_d;
   logic                              commit_ok, commit_err;

   always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
      if (!CPU_RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A CS falling edge restarts reception from any state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!cs_lvl) state_d = SHIFT;
         SHIFT:   if (cs_rise) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (cs_fall) state_d = SHIFT;
   end

   always_comb begin
      commit_ok  = 1'b0;
      commit_err = 1'b0;
      if (state_q == COMMIT) begin
         if (cnt_q == FRAME_CNT) commit_ok  = 1'b1;
         else                    commit_err = 1'b1;
      end
   end

   assign frame_ok  = commit_ok;
   assign frame_err = commit_err;

   // A clock edge coinciding with the CS rise is still taken while in SHIFT.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (cs_fall || state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == SHIFT && sck_rise) begin
         shift_d = {shift_q[FRAME_BITS-2:0], di_lvl};
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
   end

`ifdef KBD_WATCHDOG_EN
   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            wd_expired;

   assign wd_expired = (wd_q == WD_LAST);

   always_comb begin
      wd_d = wd_q;
      if (commit_ok)        wd_d = '0;
      else if (!wd_expired) wd_d = wd_q + 1'b1;
   end

   always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
      if (!CPU_RESET) wd_q <= '0;
      else            wd_q <= wd_d;
   end
`endif

   // Byte i of the frame lands MSB-first, so row i sits at the top of the register.
   always_comb begin
      row_d = row_q;
      joy_d = joy_q;
      if (commit_ok) begin
         for (int i = 0; i < KBD_ROWS; i++) begin
            row_d[i] = shift_q[FRAME_BITS-8*(i+1) +: KBD_COLS];
         end
         joy_d = shift_q[7:0];
      end
`ifdef KBD_WATCHDOG_EN
      else if (wd_expired) begin
         row_d = {KBD_ROWS{KBD_ROW_RELEASED}};
         joy_d = '0;
      end
`endif
   end

   always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
      if (!CPU_RESET) begin
         cnt_q   <= '0;
         shift_q <= '1;
         row_q   <= {KBD_ROWS{KBD_ROW_RELEASED}};
         joy_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         row_q   <= row_d;
         joy_q   <= joy_d;
      end
   end

   always_comb begin
      kd = KBD_ROW_RELEASED;
      for (int i = 0; i < KBD_ROWS; i++) begin
         if (!A_HI[i]) kd = kd & row_q[i];
      end
   end

   assign kempston = joy_q;

   logic unused_sync;
   assign unused_sync = &{1'b0, sck_lvl, sck_fall, di_rise, di_fall, shift_q[FRAME_BITS-1]};

endmodule
